// File: rtl/mmul_pcpi_seq.sv
// PCPI-side sequencer for the NxN systolic matrix-multiply coprocessor.
// It decodes custom-0 instructions, issues operand writes, and steps the array through one compute pass.
module mmul_pcpi_seq #(
  parameter int N      = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pcpi_valid,
  input  logic [31:0]       pcpi_insn,
  output logic              pcpi_wr,
  output logic [31:0]       pcpi_rd,
  output logic              pcpi_wait,
  output logic              pcpi_ready,
  output logic              cfg_we,
  output logic [4:0]        cfg_addr,
  output logic [DATA_W-1:0] cfg_data,
  output logic              arr_clr,
  output logic              arr_en,
  output logic [3:0]        arr_step,
  input  logic [N*N-1:0]    res_bits,
  output logic              busy
);

  localparam int LAST_ADDR = 3*N*N;
  localparam int LAST_STEP = 3*N-2;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_CLR, S_RUN, S_LATCH, S_RESP, S_HOLD
  } state_t;

  state_t            r_state, w_next;
  logic [4:0]        r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wr;
  logic [3:0]        r_step;
  logic [N*N-1:0]    r_res;
  logic              r_done;

  logic       w_match;
  logic [2:0] w_f3;
  logic       w_last;
  logic       w_unused;
  logic [31:0] w_status;

  assign w_f3     = pcpi_insn[14:12];
  assign w_match  = pcpi_valid && (pcpi_insn[6:0] == 7'b0001011) &&
                    (w_f3 == 3'b000 || w_f3 == 3'b101 || w_f3 == 3'b111);
  assign w_last   = (r_step == 4'(LAST_STEP));
  assign w_unused = pcpi_insn[31];
  assign w_status = {r_done, {(31-N*N){1'b0}}, r_res};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_match) begin
        case (w_f3)
          3'b000:  w_next = S_WRITE;
          3'b101:  w_next = S_RESP;
          default: w_next = S_CLR;
        endcase
      end
      S_WRITE: w_next = S_RESP;
      S_CLR:   w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_LATCH;
      S_LATCH: w_next = S_RESP;
      S_RESP:  w_next = S_HOLD;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'd0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    cfg_we     = 1'b0;
    arr_clr    = 1'b0;
    arr_en     = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_WRITE: cfg_we = (r_addr <= 5'(LAST_ADDR));
      S_CLR: begin
        arr_clr   = 1'b1;
        pcpi_wait = 1'b1;
      end
      S_RUN: begin
        arr_en    = 1'b1;
        busy      = 1'b1;
        pcpi_wait = 1'b1;
      end
      S_LATCH: pcpi_wait = 1'b1;
      S_RESP: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = r_wr ? 32'd0 : w_status;
      end
      default: ;
    endcase
  end

  // Operand capture, feed counter and result/status bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr <= '0;
      r_data <= '0;
      r_wr   <= 1'b0;
      r_step <= '0;
      r_res  <= '0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_match) begin
          r_wr <= (w_f3 == 3'b000);
          if (w_f3 == 3'b000) begin
            r_addr <= pcpi_insn[11:7];
            r_data <= pcpi_insn[15 +: DATA_W];
          end
        end
        S_WRITE: r_done <= 1'b0;
        S_CLR:   r_step <= '0;
        S_RUN:   if (!w_last) r_step <= r_step + 4'd1;
        S_LATCH: begin
          r_res  <= res_bits;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cfg_addr = r_addr;
  assign cfg_data = r_data;
  assign arr_step = r_step;

endmodule
